// File: rtl/mux_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mux_sched_pkg
// Shared types and constants for the mux_rr_scheduler block.
//   state_t        : scheduler state {IDLE, BUSY}
//   N_REQ / SEL_W  : number of requesters / width of the select code
//   onehot_to_idx  : index of the set bit in a one-hot vector
//   idx_to_onehot  : one-hot vector with the indexed bit set
// Optional build macro used by the block: MUX_SCHED_LOCK_EN
// -----------------------------------------------------------------------------
package mux_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Returns 0 for an all-zero vector; callers only use it while a grant is held.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler_if
// Bundle between the requesters (master) and the scheduler (slave).
//   req       : per-requester request, bit i = requester i
//   in        : per-requester data bit
//   gnt       : registered one-hot grant (zero when idle)
//   sel       : registered select code of the granted requester
//   out       : registered selected data bit
//   out_vld   : qualifies out
//   burst_end : pulse on the last granted cycle of a tenure
//   lock      : burst-limit override (only with MUX_SCHED_LOCK_EN defined)
// -----------------------------------------------------------------------------
interface mux_rr_scheduler_if;

    logic [mux_sched_pkg::N_REQ-1:0] req;
    logic [mux_sched_pkg::N_REQ-1:0] in;
    logic [mux_sched_pkg::N_REQ-1:0] gnt;
    logic [mux_sched_pkg::SEL_W-1:0] sel;
    logic                            out;
    logic                            out_vld;
    logic                            burst_end;
`ifdef MUX_SCHED_LOCK_EN
    logic                            lock;

    modport master (
        output req, in, lock,
        input  gnt, sel, out, out_vld, burst_end
    );

    modport slave (
        input  req, in, lock,
        output gnt, sel, out, out_vld, burst_end
    );
`else
    modport master (
        output req, in,
        input  gnt, sel, out, out_vld, burst_end
    );

    modport slave (
        input  req, in,
        output gnt, sel, out, out_vld, burst_end
    );
`endif

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: starting at index ptr and wrapping from
// the top index back to 0, return the first set bit of req.
//   req   : request vector to search
//   ptr   : starting index of the search
//   found : at least one bit of req is set
//   idx   : index of the first set bit at or after ptr (0 offset when !found)
// -----------------------------------------------------------------------------
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // rot[k] is the request that sits k positions after ptr, so the search
    // reduces to a fixed lowest-bit priority encoder on rot.
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req[ptr + SEL_W'(gi)];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        off   = '0;
        // Walk downward so the lowest set offset is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
    end

    assign idx = ptr + off;

endmodule

// File: rtl/mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler
// Round-robin scheduler owning the select of an 8:1 bit mux. Grants one
// requester at a time, bounds each tenure to MAX_BURST cycles, and registers
// the selected data bit onto a serial output with a valid flag.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mux_rr_scheduler_if.slave (req, in, gnt, sel, out, out_vld,
//          burst_end, and lock when MUX_SCHED_LOCK_EN is defined)
// Parameters:
//   MAX_BURST : longest tenure in cycles (1..16)
//   CNT_W     : tenure counter width, 2**CNT_W >= MAX_BURST
// Build option MUX_SCHED_LOCK_EN: adds bus.lock, which suspends the burst
// limit while the owner keeps requesting.
// -----------------------------------------------------------------------------
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_scheduler_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] gnt_reg,   gnt_next;
    logic [SEL_W-1:0] sel_reg,   sel_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [SEL_W-1:0] ptr_reg,   ptr_next;
    logic             out_reg;
    logic             out_vld_reg;

    // Current owner and the tenure-end decision.
    logic [SEL_W-1:0] owner;
    logic             owner_req;
    logic             cnt_last;
    logic             lock_hold;
    logic             tenure_end;
    logic             busy;

    // Search results: fresh arbitration from ptr, and the hand-over search
    // that skips the current owner.
    logic             new_found;
    logic [SEL_W-1:0] new_idx;
    logic             oth_found;
    logic [SEL_W-1:0] oth_idx;
    logic [N_REQ-1:0] oth_req;
    logic [SEL_W-1:0] oth_ptr;

    assign busy      = (state_reg == BUSY);
    assign owner     = onehot_to_idx(gnt_reg);
    assign owner_req = bus.req[owner];
    assign cnt_last  = (cnt_reg == CNT_W'(MAX_BURST - 1));

`ifdef MUX_SCHED_LOCK_EN
    assign lock_hold = bus.lock & owner_req;
`else
    assign lock_hold = 1'b0;
`endif

    // A dropped request always ends the tenure; the length limit only ends it
    // when lock is not holding it open.
    assign tenure_end = ~owner_req | (cnt_last & ~lock_hold);

    assign oth_req = bus.req & ~gnt_reg;
    assign oth_ptr = owner + SEL_W'(1);

    rr_pick u_pick_new (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .found (new_found),
        .idx   (new_idx)
    );

    rr_pick u_pick_next (
        .req   (oth_req),
        .ptr   (oth_ptr),
        .found (oth_found),
        .idx   (oth_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            sel_reg     <= '0;
            cnt_reg     <= '0;
            ptr_reg     <= '0;
            out_reg     <= 1'b0;
            out_vld_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            cnt_reg     <= cnt_next;
            ptr_reg     <= ptr_next;
            // One-cycle datapath: the bit of granted cycle t appears at t+1.
            out_reg     <= bus.in[sel_reg];
            out_vld_reg <= busy;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;

        case (state_reg)
            IDLE: begin
                if (new_found) begin
                    state_next = BUSY;
                    gnt_next   = idx_to_onehot(new_idx);
                    sel_next   = new_idx;
                    cnt_next   = '0;
                end
            end

            BUSY: begin
                if (!tenure_end) begin
                    // Saturate so a locked tenure keeps cnt pinned at the limit;
                    // dropping lock then ends the tenure in that same cycle.
                    if (!cnt_last) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    ptr_next = oth_ptr;
                    cnt_next = '0;
                    if (oth_found) begin
                        gnt_next = idx_to_onehot(oth_idx);
                        sel_next = oth_idx;
                    end else if (!owner_req) begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                    // Otherwise the owner is the only requester: fresh burst,
                    // gnt and sel stay as they are.
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_reg;
    assign bus.sel       = sel_reg;
    assign bus.out       = out_reg;
    assign bus.out_vld   = out_vld_reg;
    // An owner that withdraws early is not told its burst ended.
    assign bus.burst_end = busy & owner_req & tenure_end;

endmodule
